// File: rtl/multi_nibble_adder_pkg.sv
// Shared constants for the multi-nibble sequential adder: FSM encoding and slice geometry.
package multi_nibble_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NIBBLE_W        = 4;
  localparam int NIBBLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADD  = ST_ADD,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/multi_nibble_adder_slice.sv
// Combinational 4-bit ripple-add slice reused once per nibble by the sequencer.
module nibble_add_slice
  import multi_nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co
);

  assign {co, s4} = {1'b0, a4} + {1'b0, b4} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/multi_nibble_adder.sv
// Wide adder that steps one 4-bit slice across NIBBLES cycles, LSB nibble first.
// Optional macro MNA_SUBTRACT_EN adds a 'sub' input that turns the operation into A-B.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accepted start
// ADD   | one nibble per cycle through the slice, carry chained in carry_q
// DONE  | results visible, done pulses for this single cycle
module multi_nibble_adder
  import multi_nibble_adder_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef MNA_SUBTRACT_EN
  input  logic                  sub,
`endif
  input  logic [4*NIBBLES-1:0]  a,
  input  logic [4*NIBBLES-1:0]  b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*NIBBLES-1:0]  sum,
  output logic                  cout,
  output logic                  overflow
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     work_q, work_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic                sub_eff;
  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
  logic                slice_co;
  logic [W-1:0]        work_next;

`ifdef MNA_SUBTRACT_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  nibble_add_slice u_slice (
    .a4 (slice_a),
    .b4 (slice_b),
    .ci (carry_q),
    .s4 (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    work_d    = work_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    work_next = work_q;
    work_next[idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub_eff ? ~b : b;
          carry_d = sub_eff ? 1'b1 : cin;
          work_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        work_d  = work_next;
        carry_d = slice_co;
        if (idx_q == IDX_LAST) begin
          // Results load on the edge into DONE so they are valid alongside the done pulse.
          sum_d   = work_next;
          cout_d  = slice_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (work_next[W-1] != a_q[W-1]);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d  = idx_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_multi_nibble_adder.sv
// Self-checking bench: directed plus random operations against an arithmetic reference model.
module tb_multi_nibble_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cin, sub;
  logic [15:0] a, b;
  logic        busy, done, cout, overflow;
  logic [15:0] sum;

  logic        start2, cin2, sub2;
  logic [7:0]  a2, b2, sum2;
  logic        busy2, done2, cout2, ovf2;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] prev_sum;
  logic        prev_cout, prev_ovf;

  always #5 clk = ~clk;

  multi_nibble_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef MNA_SUBTRACT_EN
    .sub(sub),
`endif
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  multi_nibble_adder #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef MNA_SUBTRACT_EN
    .sub(sub2),
`endif
    .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, cout, sum} for a W-bit add/subtract of the effective operands.
  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
    logic [15:0] ye;
    logic [16:0] t;
    logic        ce, v;
    ye = s ? ~y : y;
    ce = s ? 1'b1 : c;
    t  = {1'b0, x} + {1'b0, ye} + {16'd0, ce};
    v  = (x[15] == ye[15]) && (t[15] != x[15]);
    return {v, t[16], t[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on the 4-nibble instance and checks every cycle of it.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       input logic ts, input bit poke);
    logic [17:0] exp;
    logic        s_eff;
`ifdef MNA_SUBTRACT_EN
    s_eff = ts;
`else
    s_eff = 1'b0;
`endif
    exp   = model16(ta, tb_v, tc, s_eff);
    start = 1'b1; a = ta; b = tb_v; cin = tc; sub = ts;
    step();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int i = 1; i <= 4; i++) begin
      chk("busy_in_add", {31'd0, busy}, 32'd1);
      chk("done_in_add", {31'd0, done}, 32'd0);
      chk("sum_hold",    {16'd0, sum},  {16'd0, prev_sum});
      chk("cout_hold",   {31'd0, cout}, {31'd0, prev_cout});
      if (poke && i == 2) begin
        start = 1'b1; a = 16'hAAAA;
      end else begin
        start = 1'b0;
      end
      step();
    end
    chk("done_pulse", {31'd0, done},     32'd1);
    chk("busy_done",  {31'd0, busy},     32'd0);
    chk("sum",        {16'd0, sum},      {16'd0, exp[15:0]});
    chk("cout",       {31'd0, cout},     {31'd0, exp[16]});
    chk("overflow",   {31'd0, overflow}, {31'd0, exp[17]});
    start = poke;
    a     = 16'hAAAA;
    step();
    start = 1'b0;
    chk("done_single", {31'd0, done}, 32'd0);
    chk("busy_after",  {31'd0, busy}, 32'd0);
    chk("sum_after",   {16'd0, sum},  {16'd0, exp[15:0]});
    if (poke) begin
      step();
      chk("no_restart", {31'd0, busy}, 32'd0);
    end
    prev_sum  = exp[15:0];
    prev_cout = exp[16];
    prev_ovf  = exp[17];
  endtask

  task automatic do_op2(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
    logic [8:0] t;
    logic       v;
    t = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tc};
    v = (ta[7] == tb_v[7]) && (t[7] != ta[7]);
    start2 = 1'b1; a2 = ta; b2 = tb_v; cin2 = tc; sub2 = 1'b0;
    step();
    start2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom);
    for (int i = 1; i <= 2; i++) begin
      chk("n2_busy", {31'd0, busy2}, 32'd1);
      chk("n2_done_early", {31'd0, done2}, 32'd0);
      step();
    end
    chk("n2_done", {31'd0, done2}, 32'd1);
    chk("n2_sum",  {24'd0, sum2},  {24'd0, t[7:0]});
    chk("n2_cout", {31'd0, cout2}, {31'd0, t[8]});
    chk("n2_ovf",  {31'd0, ovf2},  {31'd0, v});
    step();
    chk("n2_done_gone", {31'd0, done2}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    #23;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum",  {16'd0, sum},  32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf",  {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    step();

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);

    // Abort an operation in flight with reset.
    start = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum",  {16'd0, sum},  32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_ovf",  {31'd0, overflow}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("no_done_after_rst", {31'd0, done}, 32'd0);
      chk("no_busy_after_rst", {31'd0, busy}, 32'd0);
    end
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

`ifdef MNA_SUBTRACT_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
`endif

    for (int n = 0; n < 24; n++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    do_op2(8'hF0, 8'h10, 1'b0);
    do_op2(8'h7F, 8'h01, 1'b0);
    for (int n = 0; n < 6; n++) begin
      do_op2(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
